apb_master_arbiter: RTL and testbench

- Round-robin APB master that shares one APB slave port (PCLK domain) between N local requesters.
- Accepts single-beat read/write commands on a valid/ready interface and sequences the APB SETUP and ACCESS phases.
- Waits on PREADY, so it tolerates slaves configured with any WAIT_CYCLES_COUNT, and returns read data or a timeout error to the granted requester.
- Sits between testbench or SoC-side agents and apb_slave_ip.

---
 rtl/apb_master_arbiter_pkg.sv | 18 +
 rtl/apb_master_arbiter_if.sv | 43 ++++
 rtl/apb_master_arbiter_rr_arbiter.sv | 33 +++
 rtl/apb_master_arbiter.sv | 128 ++++++++++++
 tb/tb_apb_master_arbiter.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_master_arbiter_pkg.sv
// rtl/apb_master_arbiter_pkg.sv - shared APB state type and default widths
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_state_e;

  localparam int APB_ADDR_W = 8;
  localparam int APB_DATA_W = 32;

  // Index width for an N-entry one-hot vector; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_master_arbiter_if.sv
// rtl/apb_master_arbiter_if.sv - requester command/response and APB bus bundle
interface apb_master_arbiter_if
  import apb_pkg::*;
#(
  parameter int N_REQ      = 2,
  parameter int ADDR_WIDTH = APB_ADDR_W,
  parameter int DATA_WIDTH = APB_DATA_W
);

  logic [N_REQ-1:0]            req_valid;
  logic [N_REQ-1:0]            req_ready;
  logic [N_REQ-1:0]            req_write;
  logic [N_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [N_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [N_REQ-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]       rsp_rdata;
  logic                        rsp_err;

  logic [ADDR_WIDTH-1:0]       PADDR;
  logic [DATA_WIDTH-1:0]       PWDATA;
  logic [DATA_WIDTH-1:0]       PRDATA;
  logic                        PWRITE;
  logic                        PSEL;
  logic                        PENABLE;
  logic                        PREADY;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, PRDATA, PREADY,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output PADDR, PWDATA, PWRITE, PSEL, PENABLE
  );

  modport slave (
    input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
    output PRDATA, PREADY
  );

  modport requester (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/apb_master_arbiter_rr_arbiter.sv
// rtl/apb_master_arbiter_rr_arbiter.sv - combinational round-robin grant search
module rr_arbiter
  import apb_pkg::*;
#(
  parameter int N = 2,
  localparam int IW = idx_width(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  input  logic          enable_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] grant_idx_o
);

  // Search starts one past the last winner so the last winner has lowest priority.
  always_comb begin
    int   j;
    logic found;
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    j           = 0;
    for (int k = 1; k <= N; k++) begin
      j = (int'(ptr_i) + k) % N;
      if (enable_i && !found && req_i[j]) begin
        found       = 1'b1;
        grant_o[j]  = 1'b1;
        grant_idx_o = IW'(j);
      end
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// rtl/apb_master_arbiter.sv - round-robin APB master shared by N_REQ requesters
module apb_master_arbiter
  import apb_pkg::*;
#(
  parameter int N_REQ          = 2,
  parameter int ADDR_WIDTH     = APB_ADDR_W,
  parameter int DATA_WIDTH     = APB_DATA_W,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                 PCLK,
  input  logic                 PRESET,
  apb_master_arbiter_if.master bus
);

  localparam int IW = idx_width(N_REQ);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  apb_state_e            state_q;
  logic [IW-1:0]         ptr_q;
  logic [IW-1:0]         owner_q;
  logic [CW-1:0]         wait_q;
  logic                  psel_q;
  logic                  penable_q;
  logic                  pwrite_q;
  logic [ADDR_WIDTH-1:0] paddr_q;
  logic [DATA_WIDTH-1:0] pwdata_q;
  logic [N_REQ-1:0]      rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic                  rsp_err_q;

  logic                  access_done;
  logic                  timeout_hit;
  logic                  arb_en;
  logic                  any_grant;
  logic [N_REQ-1:0]      grant;
  logic [IW-1:0]         grant_idx;

  assign access_done = (state_q == ACCESS) && bus.PREADY;
  assign timeout_hit = (state_q == ACCESS) && !bus.PREADY &&
                       (wait_q == CW'(TIMEOUT_CYCLES - 1));
  // Arbitrate when idle or on the completing ACCESS cycle for back-to-back transfers.
  assign arb_en      = !PRESET && ((state_q == IDLE) || access_done);
  assign any_grant   = |grant;

  rr_arbiter #(.N(N_REQ)) u_rr (
    .req_i       (bus.req_valid),
    .ptr_i       (ptr_q),
    .enable_i    (arb_en),
    .grant_o     (grant),
    .grant_idx_o (grant_idx)
  );

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q     <= IDLE;
      ptr_q       <= IW'(N_REQ - 1);
      owner_q     <= '0;
      wait_q      <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
        end
        SETUP: begin
          penable_q <= 1'b1;
          wait_q    <= '0;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          if (bus.PREADY) begin
            rsp_valid_q <= N_REQ'(1) << owner_q;
            rsp_rdata_q <= pwrite_q ? '0 : bus.PRDATA;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            state_q     <= IDLE;
          end else if (timeout_hit) begin
            rsp_valid_q <= N_REQ'(1) << owner_q;
            rsp_err_q   <= 1'b1;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            state_q     <= IDLE;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        default: begin
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
      // A fresh grant overrides the IDLE return chosen above.
      if (any_grant) begin
        pwrite_q  <= bus.req_write[grant_idx];
        paddr_q   <= bus.req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
        pwdata_q  <= bus.req_wdata[grant_idx*DATA_WIDTH +: DATA_WIDTH];
        ptr_q     <= grant_idx;
        owner_q   <= grant_idx;
        psel_q    <= 1'b1;
        penable_q <= 1'b0;
        state_q   <= SETUP;
      end
    end
  end

  assign bus.req_ready = grant;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.PADDR     = paddr_q;
  assign bus.PWDATA    = pwdata_q;
  assign bus.PWRITE    = pwrite_q;
  assign bus.PSEL      = psel_q;
  assign bus.PENABLE   = penable_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb/tb_apb_master_arbiter.sv - randomized bench for apb_master_arbiter with reference model
module tb_apb_master_arbiter;
  import apb_pkg::*;

  localparam int N  = 3;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  apb_master_arbiter_if #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  apb_master_arbiter #(
    .N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .PCLK   (clk),
    .PRESET (rst),
    .bus    (bus)
  );

  logic [N-1:0]    rv, rw;
  logic [N*AW-1:0] ra;
  logic [N*DW-1:0] rd;
  assign bus.req_valid = rv;
  assign bus.req_write = rw;
  assign bus.req_addr  = ra;
  assign bus.req_wdata = rd;

  logic [DW-1:0] slave_mem [0:255];
  int            acc_cnt;
  int            wait_cfg;
  bit            hang;
  assign bus.PREADY = bus.PSEL && bus.PENABLE && !hang && (acc_cnt == wait_cfg);
  assign bus.PRDATA = slave_mem[bus.PADDR];

  always @(posedge clk) begin
    if (rst) acc_cnt <= 0;
    else if (bus.PSEL && bus.PENABLE) begin
      if (bus.PREADY) begin
        acc_cnt <= 0;
        if (bus.PWRITE) slave_mem[bus.PADDR] <= bus.PWDATA;
      end else acc_cnt <= acc_cnt + 1;
    end else acc_cnt <= 0;
  end

  typedef struct {
    int          cyc;
    int          idx;
    logic [DW-1:0] rdata;
    bit          err;
  } rsp_t;

  logic [DW-1:0] model_mem [0:255];
  rsp_t          rspq[$];
  int            cyc, ptr, cur_t, cur_e, free_cyc;
  logic [AW-1:0] cur_addr;
  logic          cur_wr;
  logic [DW-1:0] cur_wd;
  bit            rand_en;
  logic [N-1:0]  rand_mask;
  int            pct;
  logic [DW-1:0] last_rdata;
  int            grant_log[$];
  int            n_tests, n_fail;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    rspq.delete();
    ptr      = N - 1;
    cur_t    = -100;
    cur_e    = -100;
    free_cyc = cyc + 1;
  endtask

  task automatic tick();
    int   w;
    bit   in_win;
    rsp_t r;
    logic [N-1:0] exp_rv;
    w = -1;
    @(negedge clk);
    cyc++;
    if (rst) begin
      check("ready_in_reset", bus.req_ready, 0);
      model_reset();
    end else begin
      exp_rv = '0;
      if (rspq.size() > 0 && rspq[0].cyc == cyc) begin
        r = rspq.pop_front();
        exp_rv = N'(1) << r.idx;
        check("rsp_rdata", bus.rsp_rdata, r.rdata);
        check("rsp_err", bus.rsp_err, r.err);
        last_rdata = bus.rsp_rdata;
      end
      check("rsp_valid", bus.rsp_valid, exp_rv);

      in_win = (cyc > cur_t) && (cyc <= cur_e);
      check("psel", bus.PSEL, in_win);
      check("penable", bus.PENABLE, in_win && (cyc >= cur_t + 2));
      if (in_win) begin
        check("paddr", bus.PADDR, cur_addr);
        check("pwrite", bus.PWRITE, cur_wr);
        check("pwdata", bus.PWDATA, cur_wd);
      end

      if (cyc >= free_cyc) begin
        for (int k = 1; k <= N; k++) begin
          int j;
          j = (ptr + k) % N;
          if (w < 0 && rv[j]) w = j;
        end
      end
      check("req_ready", bus.req_ready, (w >= 0) ? (N'(1) << w) : N'(0));
      for (int i = 0; i < N; i++) if (bus.req_ready[i]) grant_log.push_back(i);

      if (w >= 0) begin
        int len;
        bit tmo;
        tmo      = hang || (wait_cfg >= TO);
        len      = tmo ? TO : wait_cfg + 1;
        ptr      = w;
        cur_t    = cyc;
        cur_e    = cyc + 1 + len;
        cur_addr = ra[w*AW +: AW];
        cur_wr   = rw[w];
        cur_wd   = rd[w*DW +: DW];
        r.cyc    = cur_e + 1;
        r.idx    = w;
        r.err    = tmo;
        r.rdata  = (cur_wr || tmo) ? '0 : model_mem[cur_addr];
        if (cur_wr && !tmo) model_mem[cur_addr] = cur_wd;
        rspq.push_back(r);
        free_cyc = tmo ? cur_e + 1 : cur_e;
      end
    end
    @(posedge clk);
    #1;
    if (w >= 0) rv[w] = 1'b0;
    if (rand_en) begin
      for (int i = 0; i < N; i++) begin
        if (rand_mask[i] && !rv[i] && $urandom_range(0, 99) < pct) begin
          rv[i]          = 1'b1;
          rw[i]          = 1'($urandom);
          ra[i*AW +: AW] = AW'($urandom_range(0, 15));
          rd[i*DW +: DW] = $urandom;
        end
      end
    end
  endtask

  task automatic issue(input int i, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    rv[i]          = 1'b1;
    rw[i]          = wr;
    ra[i*AW +: AW] = a;
    rd[i*DW +: DW] = d;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (!(rv == '0 && rspq.size() == 0 && cyc >= free_cyc) && k < 400) begin
      tick();
      k++;
    end
    if (k >= 400) check("drain_bound", k, 0);
    tick();
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    rv = '0; rw = '0; ra = '0; rd = '0;
    rst = 1'b1; hang = 1'b0; wait_cfg = 0;
    rand_en = 1'b0; rand_mask = '0; pct = 0; cyc = 0; last_rdata = '0;
    for (int a = 0; a < 256; a++) begin
      slave_mem[a] = $urandom;
      model_mem[a] = slave_mem[a];
    end
    model_reset();
    tick();
    tick();
    rv = '1;
    #1;
    check("rst_req_ready", bus.req_ready, 0);
    rv = '0;
    check("rst_psel", bus.PSEL, 0);
    check("rst_penable", bus.PENABLE, 0);
    check("rst_pwrite", bus.PWRITE, 0);
    check("rst_paddr", bus.PADDR, 0);
    check("rst_pwdata", bus.PWDATA, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_rdata", bus.rsp_rdata, 0);
    check("rst_rsp_err", bus.rsp_err, 0);
    rst = 1'b0;

    issue(0, 1'b1, 8'h04, 32'hDEADBEEF);
    drain();
    issue(0, 1'b0, 8'h04, 32'h0);
    drain();
    check("read_back_0x04", last_rdata, 32'hDEADBEEF);

    wait_cfg = 3;
    issue(1, 1'b0, 8'h10, 32'h0);
    drain();

    wait_cfg = 0;
    grant_log.delete();
    rand_mask = 3'b011; pct = 100; rand_en = 1'b1;
    repeat (14) tick();
    rand_en = 1'b0;
    drain();
    for (int k = 0; k < 6; k++) begin
      if (k < grant_log.size()) check("rr_alternate", grant_log[k], k % 2);
      else check("rr_count", grant_log.size(), 6);
    end

    hang = 1'b1;
    issue(0, 1'b0, 8'h20, 32'h0);
    drain();
    check("timeout_err", bus.rsp_err, 0);
    hang = 1'b0;

    wait_cfg = TO - 1;
    issue(1, 1'b1, 8'h21, 32'hA5A5_0001);
    drain();
    wait_cfg = TO;
    issue(2, 1'b1, 8'h22, 32'hA5A5_0002);
    drain();
    wait_cfg = 0;
    issue(0, 1'b0, 8'h22, 32'h0);
    drain();

    wait_cfg = 3;
    issue(0, 1'b0, 8'h30, 32'h0);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_cfg = 0;
    issue(1, 1'b0, 8'h31, 32'h0);
    issue(0, 1'b0, 8'h32, 32'h0);
    grant_log.delete();
    drain();
    if (grant_log.size() > 0) check("post_reset_first", grant_log[0], 0);
    else check("post_reset_grants", grant_log.size(), 2);

    issue(1, 1'b1, 8'h08, 32'h12345678);
    drain();

    for (int ph = 0; ph < 4; ph++) begin
      wait_cfg  = (ph == 3) ? TO + $urandom_range(0, 2) : $urandom_range(0, 3);
      rand_mask = '1;
      pct       = 20 + 10 * ph;
      rand_en   = 1'b1;
      repeat (300) tick();
      rand_en = 1'b0;
      drain();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
